pf_multi_source_queue: RTL and testbench

- Next-generation prefetch request front end for the L2 prefetch port.
- Accepts requests from NUM_SRC independent prefetch engines (SPP, BOP, ...), each through its own FIFO.
- Drops requests for blocks issued recently, using a small FIFO-replaced filter.
- Round-robin arbitrates the survivors onto the single pf_req channel consumed by the L2 request path.

---
 rtl/pf_multi_source_queue.sv | 180 ++++++++++++++++++
 tb/tb_pf_multi_source_queue.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_multi_source_queue.sv
// pf_multi_source_queue
//   Prefetch request front end for the L2 prefetch port. Each prefetch engine
//   owns a small FIFO. Requests for blocks issued recently are dropped against
//   a FIFO-replaced filter, and the survivors are round-robin arbitrated onto
//   the single pf_req channel.
//
// Ports
//   clock, reset        : clock and synchronous active-high reset
//   in_valid/in_ready   : per-source handshake (one bit per source)
//   in_tag/in_set/...   : packed per-source request fields, source i at [i*W +: W]
//   flush               : invalidate every filter entry at the next edge
//   pf_req_valid/ready  : downstream handshake
//   pf_req_bits_*       : granted FIFO head, driven combinationally
//   drop_cnt            : saturating count of filtered requests
//   grant_src           : index of the source being presented (held when idle)
module pf_multi_source_queue #(
  parameter int NUM_SRC = 2,
  parameter int TAG_W   = 21,
  parameter int SET_W   = 9,
  parameter int SRC_W   = 7,
  parameter int QDEPTH  = 4,
  parameter int FILT_N  = 8,
  localparam int GRANT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         in_valid,
  output logic [NUM_SRC-1:0]         in_ready,
  input  logic [NUM_SRC*TAG_W-1:0]   in_tag,
  input  logic [NUM_SRC*SET_W-1:0]   in_set,
  input  logic [NUM_SRC-1:0]         in_needT,
  input  logic [NUM_SRC*SRC_W-1:0]   in_source,
  input  logic [NUM_SRC-1:0]         in_isBOP,
  input  logic                       flush,
  input  logic                       pf_req_ready,
  output logic                       pf_req_valid,
  output logic [TAG_W-1:0]           pf_req_bits_tag,
  output logic [SET_W-1:0]           pf_req_bits_set,
  output logic                       pf_req_bits_needT,
  output logic [SRC_W-1:0]           pf_req_bits_source,
  output logic                       pf_req_bits_isBOP,
  output logic [15:0]                drop_cnt,
  output logic [GRANT_W-1:0]         grant_src
);

  localparam int PTR_W  = $clog2(QDEPTH) + 1;
  localparam int IDX_W  = PTR_W - 1;
  localparam int FPTR_W = (FILT_N > 1) ? $clog2(FILT_N) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set;
    logic             needT;
    logic [SRC_W-1:0] source;
    logic             isBOP;
  } req_t;

  req_t               fifo_mem [NUM_SRC][QDEPTH];
  logic [PTR_W-1:0]   wr_ptr   [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr   [NUM_SRC];
  req_t               in_req   [NUM_SRC];
  logic [NUM_SRC-1:0] empty, full, accept, drop, push, pop;

  logic [FILT_N-1:0]  filt_valid;
  logic [FILT_N-1:0]  filt_needT;
  logic [TAG_W-1:0]   filt_tag [FILT_N];
  logic [SET_W-1:0]   filt_set [FILT_N];
  logic [FPTR_W-1:0]  filt_wptr;

  logic [GRANT_W-1:0] rr_ptr, grant, last_grant;
  logic               lock, fire;
  req_t               head;
  logic [4:0]         drop_num;
  logic [16:0]        drop_sum;

  // FIFO status, unpacking of the request buses and the filter lookup.
  // The lookup always sees the filter contents from before this edge, so a
  // same-cycle fire or flush never affects the drop decision of this cycle.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      in_req[i]        = '0;
      in_req[i].tag    = in_tag[i*TAG_W +: TAG_W];
      in_req[i].set    = in_set[i*SET_W +: SET_W];
      in_req[i].needT  = in_needT[i];
      in_req[i].source = in_source[i*SRC_W +: SRC_W];
      in_req[i].isBOP  = in_isBOP[i];
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PTR_W-1] != rd_ptr[i][PTR_W-1]) &&
                 (wr_ptr[i][IDX_W-1:0] == rd_ptr[i][IDX_W-1:0]);
      in_ready[i] = !full[i];
      accept[i]   = in_valid[i] && !full[i];
      drop[i]     = 1'b0;
      for (int f = 0; f < FILT_N; f++) begin
        // A needT request that hits a needT=0 entry is an upgrade, not a repeat.
        if (filt_valid[f] && (filt_tag[f] == in_req[i].tag) &&
            (filt_set[f] == in_req[i].set) && (filt_needT[f] || !in_req[i].needT))
          drop[i] = accept[i];
      end
      push[i]  = accept[i] && !drop[i];
      drop_num = drop_num + 5'(drop[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_num);
  end

  // Round-robin grant. While a presented request is stalled the previous
  // grant is held so the output bits cannot change before the handshake.
  always_comb begin
    logic                found;
    logic [GRANT_W-1:0]  cand;
    found        = 1'b0;
    cand         = '0;
    grant        = last_grant;
    pf_req_valid = |(~empty);
    if (!lock) begin
      for (int off = 1; off <= NUM_SRC; off++) begin
        cand = GRANT_W'((int'(rr_ptr) + off) % NUM_SRC);
        if (!found && !empty[cand]) begin
          grant = cand;
          found = 1'b1;
        end
      end
    end
    head = fifo_mem[grant][rd_ptr[grant][IDX_W-1:0]];
    fire = pf_req_valid && pf_req_ready;
    for (int i = 0; i < NUM_SRC; i++)
      pop[i] = fire && (grant == GRANT_W'(i));
    grant_src = pf_req_valid ? grant : last_grant;
  end

  assign pf_req_bits_tag    = head.tag;
  assign pf_req_bits_set    = head.set;
  assign pf_req_bits_needT  = head.needT;
  assign pf_req_bits_source = head.source;
  assign pf_req_bits_isBOP  = head.isBOP;

  // Control state: pointers, arbitration state, filter valid bits, counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      filt_valid <= '0;
      filt_wptr  <= '0;
      rr_ptr     <= GRANT_W'(NUM_SRC - 1);
      last_grant <= '0;
      lock       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      lock     <= pf_req_valid && !pf_req_ready;
      if (pf_req_valid) last_grant <= grant;
      if (fire) begin
        rr_ptr                <= grant;
        filt_valid[filt_wptr] <= 1'b1;
        filt_wptr             <= filt_wptr + 1'b1;
      end
      // Placed last so it overrides a same-cycle filter write.
      if (flush) filt_valid <= '0;
    end
  end

  // Storage arrays; their contents only matter where a valid bit or pointer
  // says so, so they need no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (push[i]) fifo_mem[i][wr_ptr[i][IDX_W-1:0]] <= in_req[i];
    if (fire) begin
      filt_tag[filt_wptr]   <= head.tag;
      filt_set[filt_wptr]   <= head.set;
      filt_needT[filt_wptr] <= head.needT;
    end
  end

endmodule

// File: tb/tb_pf_multi_source_queue.sv
// tb_pf_multi_source_queue
//   Self-checking bench for pf_multi_source_queue (NUM_SRC=2, QDEPTH=4,
//   FILT_N=8). Every request expected on pf_req is pushed to a scoreboard queue
//   in the order it should be issued; each fired request is popped and compared
//   field by field, including the granted source index.
module tb_pf_multi_source_queue;

  localparam int NUM_SRC = 2;
  localparam int TAG_W   = 21;
  localparam int SET_W   = 9;
  localparam int SRC_W   = 7;

  logic                     clock;
  logic                     reset;
  logic [NUM_SRC-1:0]       in_valid;
  logic [NUM_SRC-1:0]       in_ready;
  logic [NUM_SRC*TAG_W-1:0] in_tag;
  logic [NUM_SRC*SET_W-1:0] in_set;
  logic [NUM_SRC-1:0]       in_needT;
  logic [NUM_SRC*SRC_W-1:0] in_source;
  logic [NUM_SRC-1:0]       in_isBOP;
  logic                     flush;
  logic                     pf_req_ready;
  logic                     pf_req_valid;
  logic [TAG_W-1:0]         pf_req_bits_tag;
  logic [SET_W-1:0]         pf_req_bits_set;
  logic                     pf_req_bits_needT;
  logic [SRC_W-1:0]         pf_req_bits_source;
  logic                     pf_req_bits_isBOP;
  logic [15:0]              drop_cnt;
  logic [0:0]               grant_src;

  typedef struct packed {
    logic [0:0]       src;
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set;
    logic             needT;
    logic [SRC_W-1:0] source;
    logic             isBOP;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   exp_drop;

  pf_multi_source_queue dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_set(in_set), .in_needT(in_needT),
    .in_source(in_source), .in_isBOP(in_isBOP),
    .flush(flush), .pf_req_ready(pf_req_ready), .pf_req_valid(pf_req_valid),
    .pf_req_bits_tag(pf_req_bits_tag), .pf_req_bits_set(pf_req_bits_set),
    .pf_req_bits_needT(pf_req_bits_needT), .pf_req_bits_source(pf_req_bits_source),
    .pf_req_bits_isBOP(pf_req_bits_isBOP), .drop_cnt(drop_cnt), .grant_src(grant_src)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one source's request; when issue is set, the request is expected on
  // pf_req and goes to the scoreboard in call order.
  task automatic applyStimulus(input int s, input logic [TAG_W-1:0] tag,
                               input logic [SET_W-1:0] set, input logic needT,
                               input logic isBOP, input bit issue);
    logic [SRC_W-1:0] sid;
    sid = SRC_W'(s * 5 + 3);
    in_valid[s]                  = 1'b1;
    in_tag[s*TAG_W +: TAG_W]     = tag;
    in_set[s*SET_W +: SET_W]     = set;
    in_needT[s]                  = needT;
    in_source[s*SRC_W +: SRC_W]  = sid;
    in_isBOP[s]                  = isBOP;
    if (issue)
      exp_q.push_back('{src: 1'(s), tag: tag, set: set, needT: needT, source: sid, isBOP: isBOP});
  endtask

  task automatic clearInputs();
    in_valid = '0;
  endtask

  // One clock cycle. Outputs are sampled 2 units after the previous edge;
  // a request presented with ready high fires at the coming edge and is
  // matched against the scoreboard head.
  task automatic cycle();
    exp_t e;
    exp_t got;
    #1;
    if (pf_req_valid && pf_req_ready) begin
      got = '{src: grant_src, tag: pf_req_bits_tag, set: pf_req_bits_set,
              needT: pf_req_bits_needT, source: pf_req_bits_source, isBOP: pf_req_bits_isBOP};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_issue: got src=%0d tag=%h set=%h needT=%0d, expected no request",
                 got.src, got.tag, got.set, got.needT);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("[TB] FAIL scoreboard: got src=%0d tag=%h set=%h needT=%0d source=%h isBOP=%0d, expected src=%0d tag=%h set=%h needT=%0d source=%h isBOP=%0d",
                   got.src, got.tag, got.set, got.needT, got.source, got.isBOP,
                   e.src, e.tag, e.set, e.needT, e.source, e.isBOP);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Let the queues empty with ready high, bounded by a cycle budget.
  task automatic drain();
    pf_req_ready = 1'b1;
    for (int n = 0; n < 32 && pf_req_valid; n++) cycle();
    checks++;
    if (pf_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: pf_req_valid=%b after 32 cycles, expected 0", pf_req_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    checks++;
    if ({pf_req_valid, drop_cnt, grant_src, in_ready} !== {1'b0, 16'd0, 1'b0, 2'b11}) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b drop=%0d grant=%0d ready=%b, expected 0 0 0 11",
               pf_req_valid, drop_cnt, grant_src, in_ready);
    end
  endtask

  task automatic test_issue();
    pf_req_ready = 1'b1;
    applyStimulus(0, 21'h10, 9'h5, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({in_ready[0], pf_req_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL no_bypass: ready0=%b valid=%b, expected 1 0", in_ready[0], pf_req_valid);
    end
    cycle();
    clearInputs();
    checks++;
    if ({pf_req_valid, pf_req_bits_tag, pf_req_bits_set, grant_src, drop_cnt} !==
        {1'b1, 21'h10, 9'h5, 1'b0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL first_issue: valid=%b tag=%h set=%h grant=%0d drop=%0d, expected 1 10 5 0 0",
               pf_req_valid, pf_req_bits_tag, pf_req_bits_set, grant_src, drop_cnt);
    end
    cycle();
  endtask

  task automatic test_filter_drop();
    applyStimulus(1, 21'h10, 9'h5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (in_ready[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_ready: in_ready[1]=%b expected 1", in_ready[1]);
    end
    cycle();
    clearInputs();
    exp_drop = 1;
    checks++;
    if ({pf_req_valid, drop_cnt} !== {1'b0, 16'(exp_drop)}) begin
      errors++;
      $display("[TB] FAIL drop_repeat: valid=%b drop=%0d, expected 0 %0d", pf_req_valid, drop_cnt, exp_drop);
    end
    applyStimulus(1, 21'h10, 9'h5, 1'b1, 1'b1, 1'b1);
    cycle();
    clearInputs();
    checks++;
    if ({pf_req_valid, drop_cnt} !== {1'b1, 16'(exp_drop)}) begin
      errors++;
      $display("[TB] FAIL needT_upgrade: valid=%b drop=%0d, expected 1 %0d", pf_req_valid, drop_cnt, exp_drop);
    end
    cycle();
    applyStimulus(0, 21'h10, 9'h5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 21'h10, 9'h5, 1'b1, 1'b0, 1'b0);
    cycle();
    clearInputs();
    exp_drop += 2;
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("[TB] FAIL dual_drop: drop=%0d expected %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_round_robin();
    pf_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 21'(32'h300 + k), 9'(32'h10 + k), 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 21'(32'h400 + k), 9'(32'h20 + k), 1'b1, 1'b1, 1'b1);
      checks++;
      if (in_ready !== 2'b11) begin
        errors++;
        $display("[TB] FAIL rr_fill_ready: in_ready=%b expected 11", in_ready);
      end
      cycle();
    end
    clearInputs();
    pf_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({pf_req_valid, grant_src} !== {1'b1, 1'(i % 2)}) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: valid=%b grant=%0d, expected 1 %0d", i, pf_req_valid, grant_src, i % 2);
      end
      cycle();
    end
    checks++;
    if (pf_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rr_done: valid=%b expected 0", pf_req_valid);
    end
  endtask

  task automatic test_lock();
    // One source-0 issue first, so an unlocked scan would now favour source 1.
    pf_req_ready = 1'b1;
    applyStimulus(0, 21'h600, 9'h1, 1'b0, 1'b0, 1'b1);
    cycle();
    clearInputs();
    drain();
    pf_req_ready = 1'b0;
    applyStimulus(0, 21'h610, 9'h2, 1'b1, 1'b0, 1'b1);
    cycle();
    clearInputs();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) applyStimulus(1, 21'(32'h620 + c), 9'h3, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({pf_req_valid, grant_src, pf_req_bits_tag, pf_req_bits_set} !== {1'b1, 1'b0, 21'h610, 9'h2}) begin
        errors++;
        $display("[TB] FAIL lock_hold[%0d]: valid=%b grant=%0d tag=%h set=%h, expected 1 0 610 2",
                 c, pf_req_valid, grant_src, pf_req_bits_tag, pf_req_bits_set);
      end
      cycle();
      clearInputs();
    end
    pf_req_ready = 1'b1;
    checks++;
    if (grant_src !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_release_first: grant=%0d expected 0", grant_src);
    end
    cycle();
    checks++;
    if (grant_src !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_release_second: grant=%0d expected 1", grant_src);
    end
    drain();
  endtask

  task automatic test_full();
    pf_req_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 21'(32'h700 + c), 9'h4, 1'b0, 1'b0, 1'b1);
      checks++;
      if (in_ready[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fill_ready[%0d]: in_ready[0]=%b expected 1", c, in_ready[0]);
      end
      cycle();
    end
    clearInputs();
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ready: in_ready[0]=%b expected 0", in_ready[0]);
    end
    applyStimulus(0, 21'h7F0, 9'h4, 1'b0, 1'b0, 1'b0);
    cycle();
    clearInputs();
    // Dequeue cycle: still full, so a new request is refused this cycle.
    pf_req_ready = 1'b1;
    applyStimulus(0, 21'h7F1, 9'h4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_no_bypass: in_ready[0]=%b expected 0", in_ready[0]);
    end
    cycle();
    clearInputs();
    pf_req_ready = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_deq: in_ready[0]=%b expected 1", in_ready[0]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    pf_req_ready = 1'b1;
    applyStimulus(0, 21'h800, 9'h6, 1'b0, 1'b0, 1'b1);
    cycle();
    clearInputs();
    // Identical request arrives while the first one fires: not dropped.
    applyStimulus(1, 21'h800, 9'h6, 1'b0, 1'b0, 1'b1);
    cycle();
    clearInputs();
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("[TB] FAIL fire_cycle_enqueue: drop=%0d expected %0d", drop_cnt, exp_drop);
    end
    drain();
    applyStimulus(0, 21'h800, 9'h6, 1'b0, 1'b0, 1'b0);
    cycle();
    clearInputs();
    exp_drop++;
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("[TB] FAIL repeat_after_fire: drop=%0d expected %0d", drop_cnt, exp_drop);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 21'(32'h810 + i), 9'h7, 1'b0, 1'b0, 1'b1);
      if (i > 0) begin
        checks++;
        if (pf_req_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stream_valid[%0d]: valid=%b expected 1", i, pf_req_valid);
        end
      end
      cycle();
    end
    clearInputs();
    checks++;
    if (pf_req_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stream_last: valid=%b expected 1", pf_req_valid);
    end
    cycle();
    checks++;
    if (pf_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_throughput: valid=%b expected 0", pf_req_valid);
    end
  endtask

  task automatic test_filter_replace();
    pf_req_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 21'(32'h900 + k), 9'h8, 1'b0, 1'b0, 1'b1);
      cycle();
    end
    clearInputs();
    drain();
    applyStimulus(0, 21'h900, 9'h8, 1'b0, 1'b0, 1'b1);
    cycle();
    clearInputs();
    checks++;
    if ({pf_req_valid, drop_cnt} !== {1'b1, 16'(exp_drop)}) begin
      errors++;
      $display("[TB] FAIL evicted_entry: valid=%b drop=%0d, expected 1 %0d", pf_req_valid, drop_cnt, exp_drop);
    end
    drain();
    applyStimulus(0, 21'h908, 9'h8, 1'b0, 1'b0, 1'b0);
    cycle();
    clearInputs();
    exp_drop++;
    checks++;
    if ({pf_req_valid, drop_cnt} !== {1'b0, 16'(exp_drop)}) begin
      errors++;
      $display("[TB] FAIL recent_entry: valid=%b drop=%0d, expected 0 %0d", pf_req_valid, drop_cnt, exp_drop);
    end
    // Flush cycle: the check still uses the pre-flush contents.
    flush = 1'b1;
    applyStimulus(1, 21'h908, 9'h8, 1'b0, 1'b0, 1'b0);
    cycle();
    clearInputs();
    flush = 1'b0;
    exp_drop++;
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("[TB] FAIL flush_cycle_check: drop=%0d expected %0d", drop_cnt, exp_drop);
    end
    applyStimulus(0, 21'h908, 9'h8, 1'b0, 1'b0, 1'b1);
    cycle();
    clearInputs();
    checks++;
    if ({pf_req_valid, drop_cnt} !== {1'b1, 16'(exp_drop)}) begin
      errors++;
      $display("[TB] FAIL after_flush: valid=%b drop=%0d, expected 1 %0d", pf_req_valid, drop_cnt, exp_drop);
    end
    drain();
    // Flush coinciding with a fire must also kill the entry being written.
    applyStimulus(0, 21'h950, 9'h9, 1'b1, 1'b0, 1'b1);
    cycle();
    clearInputs();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    applyStimulus(0, 21'h950, 9'h9, 1'b1, 1'b0, 1'b1);
    cycle();
    clearInputs();
    checks++;
    if ({pf_req_valid, drop_cnt} !== {1'b1, 16'(exp_drop)}) begin
      errors++;
      $display("[TB] FAIL flush_vs_write: valid=%b drop=%0d, expected 1 %0d", pf_req_valid, drop_cnt, exp_drop);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    pf_req_ready = 1'b0;
    applyStimulus(0, 21'hA00, 9'h1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 21'hA01, 9'h1, 1'b0, 1'b0, 1'b0);
    cycle();
    clearInputs();
    applyStimulus(0, 21'hA02, 9'h1, 1'b0, 1'b0, 1'b0);
    cycle();
    clearInputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_drop = 0;
    checks++;
    if ({pf_req_valid, drop_cnt, grant_src, in_ready} !== {1'b0, 16'd0, 1'b0, 2'b11}) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: valid=%b drop=%0d grant=%0d ready=%b, expected 0 0 0 11",
               pf_req_valid, drop_cnt, grant_src, in_ready);
    end
    // Filter was cleared, so a block issued before reset goes out again.
    pf_req_ready = 1'b1;
    applyStimulus(0, 21'h908, 9'h8, 1'b0, 1'b0, 1'b1);
    cycle();
    clearInputs();
    checks++;
    if ({pf_req_valid, drop_cnt} !== {1'b1, 16'd0}) begin
      errors++;
      $display("[TB] FAIL filter_after_reset: valid=%b drop=%0d, expected 1 0", pf_req_valid, drop_cnt);
    end
    drain();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    exp_drop     = 0;
    reset        = 1'b1;
    flush        = 1'b0;
    pf_req_ready = 1'b0;
    in_valid     = '0;
    in_tag       = '0;
    in_set       = '0;
    in_needT     = '0;
    in_source    = '0;
    in_isBOP     = '0;
    test_reset();
    test_issue();
    test_filter_drop();
    test_round_robin();
    test_lock();
    test_full();
    test_back_to_back();
    test_filter_replace();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: %0d requests never issued, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
